// File: rtl/config_chain_ctrl_pkg.sv
// Shared types and constants for the scan-chain configuration loader.
package config_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    LOAD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int          CLEAR_CYCLES = 2;
  localparam logic [15:0] CRC_POLY     = 16'h1021;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;

endpackage

// File: rtl/config_chain_crc16.sv
// Serial CRC-16-CCITT over the chain bitstream, one bit per enabled cycle.
// Result is registered; init wins over en; no backpressure.
module config_chain_crc16
  import config_chain_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= 16'h0000;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/config_chain_ctrl.sv
// Scan-chain loader: clears the chain, then shifts CHAIN_LEN bitstream bits LSB first.
// Word accepted at edge t drives bit 0 in cycle t+1; starvation stalls the chain. CRC via CONFIG_CHAIN_CRC_EN.
module config_chain_ctrl
  import config_chain_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              sc_head,
  output logic              sc_shift_en,
  output logic              sc_reset,
  output logic              busy,
  output logic              done,
  output logic [15:0]       crc
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  sr_cnt;
  logic [15:0]       bit_cnt;
  logic [1:0]        clr_cnt;
  logic              rst_hold;
  logic              shift;
  logic              accept;
  logic              last_bit;
  logic [16:0]       committed;

  assign shift     = (state == LOAD) && (sr_cnt != '0);
  assign last_bit  = shift && (bit_cnt == 16'(CHAIN_LEN - 1));
  // Bits already shifted plus bits still queued; a new word is only useful if the chain needs more.
  assign committed = {1'b0, bit_cnt} + 17'(sr_cnt);
  assign word_ready = (state == LOAD) && (sr_cnt <= CNT_W'(1)) && (committed < 17'(CHAIN_LEN));
  assign accept     = word_valid && word_ready;

  assign sc_shift_en = shift;
  assign sc_head     = shift & sr[0];
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign sc_reset    = rst_hold | (state == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      sr_cnt   <= '0;
      bit_cnt  <= '0;
      clr_cnt  <= '0;
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        sr_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= CLEAR;
              clr_cnt <= '0;
              bit_cnt <= '0;
              sr_cnt  <= '0;
            end
          end
          CLEAR: begin
            if (clr_cnt == 2'(CLEAR_CYCLES - 1)) state <= LOAD;
            else clr_cnt <= clr_cnt + 2'd1;
          end
          LOAD: begin
            if (shift) bit_cnt <= bit_cnt + 16'd1;
            // Final bit: leftover bits of the current word are dropped.
            if (last_bit) begin
              state  <= FINISH;
              sr_cnt <= '0;
            end else if (accept) begin
              sr     <= word_data;
              sr_cnt <= CNT_W'(WORD_W);
            end else if (shift) begin
              sr     <= sr >> 1;
              sr_cnt <= sr_cnt - 1'b1;
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CONFIG_CHAIN_CRC_EN
  config_chain_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (state == CLEAR),
    .en    (shift),
    .din   (sr[0]),
    .crc   (crc)
  );
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_config_chain_ctrl.sv
// Directed bench: three loaders (CHAIN_LEN 16, 12, 8) share stimulus; each test targets one.
module tb_config_chain_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       word_valid;
  logic [7:0] word_data;

  logic [2:0]  rdy, sh, hd, scr, bsy, dn;
  logic [15:0] crc_o [3];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] wq [$];

`ifdef CONFIG_CHAIN_CRC_EN
  localparam logic [15:0] CRC_EXP = 16'hE1F0;
`else
  localparam logic [15:0] CRC_EXP = 16'h0000;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    config_chain_ctrl #(.CHAIN_LEN(16 - 4 * g), .WORD_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .word_valid  (word_valid),
      .word_data   (word_data),
      .word_ready  (rdy[g]),
      .sc_head     (hd[g]),
      .sc_shift_en (sh[g]),
      .sc_reset    (scr[g]),
      .busy        (bsy[g]),
      .done        (dn[g]),
      .crc         (crc_o[g])
    );
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Starts a load on DUT d and plays words from wq; all observation happens at negedges.
  task automatic run_load(input int d, input int gap, input int stop_at, input bit stop_by_reset,
                          output logic [31:0] bits, output int nbits, output int ndone,
                          output int starve, output int bad_head, output int nclr);
    int gap_left;
    bit first_taken;
    bits = '0; nbits = 0; ndone = 0; starve = 0; bad_head = 0; nclr = 0;
    gap_left = gap; first_taken = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (scr[d]) nclr++;
      if (dn[d]) ndone++;
      if (sh[d]) begin
        if (nbits < 32) bits[nbits] = hd[d];
        nbits++;
      end else begin
        if (hd[d]) bad_head++;
        if (nbits > 0 && bsy[d] && !dn[d]) starve++;
      end
      if (stop_at > 0 && nbits == stop_at) begin
        word_valid = 1'b0;
        if (stop_by_reset) reset = 1'b1;
        else abort = 1'b1;
        return;
      end
      if (dn[d]) begin
        word_valid = 1'b0;
        return;
      end
      word_valid = 1'b0;
      if (wq.size() > 0) begin
        if (rdy[d] && first_taken && gap_left > 0) begin
          gap_left--;
        end else begin
          word_valid = 1'b1;
          word_data  = wq[0];
          if (rdy[d]) begin
            void'(wq.pop_front());
            first_taken = 1'b1;
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({rdy[0], sh[0], hd[0], bsy[0], dn[0]} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy/sh/hd/busy/done=%b expected 00000", {rdy[0], sh[0], hd[0], bsy[0], dn[0]});
    end
    tests_run++;
    if (scr[0] !== 1'b1) begin
      tests_failed++; $display("FAIL reset_sc_reset: got %b expected 1", scr[0]);
    end
    tests_run++;
    if (crc_o[0] !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_crc: got %h expected 0000", crc_o[0]);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (scr[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release: sc_reset=%b busy=%b expected 0 0", scr[0], bsy[0]);
    end
  endtask

  task automatic test_basic();
    logic [31:0] bits; int nbits, ndone, starve, bad_head, nclr;
    do_reset();
    wq = '{8'hA5, 8'h3C};
    run_load(0, 0, 0, 1'b0, bits, nbits, ndone, starve, bad_head, nclr);
    repeat (3) begin
      @(negedge clk);
      if (dn[0]) ndone++;
    end
    tests_run++;
    if (nbits !== 16 || bits[15:0] !== 16'h3CA5) begin
      tests_failed++; $display("FAIL basic_bits: got %0d bits %h expected 16 bits 3ca5", nbits, bits[15:0]);
    end
    tests_run++;
    if (ndone !== 1) begin
      tests_failed++; $display("FAIL basic_done: got %0d pulses expected 1", ndone);
    end
    tests_run++;
    if (nclr !== 2) begin
      tests_failed++; $display("FAIL basic_clear: sc_reset cycles %0d expected 2", nclr);
    end
    tests_run++;
    if (starve !== 0 || bad_head !== 0) begin
      tests_failed++; $display("FAIL basic_stream: stalls %0d head_glitches %0d expected 0 0", starve, bad_head);
    end
    tests_run++;
    if (bsy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL basic_idle: busy %b expected 0", bsy[0]);
    end
  endtask

  task automatic test_partial();
    logic [31:0] bits; int nbits, ndone, starve, bad_head, nclr, rdy_hi, sh_hi;
    do_reset();
    wq = '{8'hFF, 8'h0F, 8'hAA};
    run_load(1, 0, 0, 1'b0, bits, nbits, ndone, starve, bad_head, nclr);
    tests_run++;
    if (nbits !== 12 || bits[11:0] !== 12'hFFF) begin
      tests_failed++; $display("FAIL partial_bits: got %0d bits %h expected 12 bits fff", nbits, bits[11:0]);
    end
    tests_run++;
    if (ndone !== 1 || wq.size() !== 1) begin
      tests_failed++; $display("FAIL partial_words: done %0d leftover %0d expected 1 1", ndone, wq.size());
    end
    word_valid = 1'b1; word_data = 8'hAA;
    rdy_hi = 0; sh_hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdy[1]) rdy_hi++;
      if (sh[1]) sh_hi++;
    end
    word_valid = 1'b0;
    wq.delete();
    tests_run++;
    if (rdy_hi !== 0 || sh_hi !== 0) begin
      tests_failed++; $display("FAIL partial_after: ready cycles %0d shift cycles %0d expected 0 0", rdy_hi, sh_hi);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] bits; int nbits, ndone, starve, bad_head, nclr;
    do_reset();
    wq = '{8'hA5, 8'h3C};
    run_load(0, 5, 0, 1'b0, bits, nbits, ndone, starve, bad_head, nclr);
    tests_run++;
    if (starve !== 5) begin
      tests_failed++; $display("FAIL starve_stall: got %0d idle cycles expected 5", starve);
    end
    tests_run++;
    if (nbits !== 16 || bits[15:0] !== 16'h3CA5 || ndone !== 1) begin
      tests_failed++; $display("FAIL starve_bits: got %0d bits %h done %0d expected 16 3ca5 1", nbits, bits[15:0], ndone);
    end
    tests_run++;
    if (bad_head !== 0) begin
      tests_failed++; $display("FAIL starve_head: head high while idle %0d times expected 0", bad_head);
    end
  endtask

  task automatic test_abort();
    logic [31:0] bits; int nbits, ndone, starve, bad_head, nclr, late;
    do_reset();
    wq = '{8'hA5, 8'h3C};
    run_load(0, 0, 7, 1'b0, bits, nbits, ndone, starve, bad_head, nclr);
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (bsy[0] !== 1'b0 || ndone !== 0) begin
      tests_failed++; $display("FAIL abort_idle: busy %b done %0d expected 0 0", bsy[0], ndone);
    end
    late = 0;
    repeat (5) begin
      @(negedge clk);
      if (dn[0] || sh[0]) late++;
    end
    tests_run++;
    if (late !== 0) begin
      tests_failed++; $display("FAIL abort_quiet: %0d done/shift cycles expected 0", late);
    end
    wq = '{8'hA5, 8'h3C};
    run_load(0, 0, 0, 1'b0, bits, nbits, ndone, starve, bad_head, nclr);
    tests_run++;
    if (nclr !== 2 || ndone !== 1 || nbits !== 16) begin
      tests_failed++; $display("FAIL abort_rerun: clear %0d done %0d bits %0d expected 2 1 16", nclr, ndone, nbits);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] bits; int nbits, ndone, starve, bad_head, nclr, act;
    do_reset();
    wq = '{8'hA5, 8'h3C};
    run_load(0, 0, 9, 1'b1, bits, nbits, ndone, starve, bad_head, nclr);
    #1;
    tests_run++;
    if ({rdy[0], sh[0], hd[0], bsy[0], dn[0], scr[0]} !== 6'b000001 || crc_o[0] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midreset_async: rdy/sh/hd/busy/done/sc_reset=%b crc=%h expected 000001 0000",
               {rdy[0], sh[0], hd[0], bsy[0], dn[0], scr[0]}, crc_o[0]);
    end
    @(negedge clk);
    reset = 1'b0; word_valid = 1'b1; word_data = 8'hFF;
    @(negedge clk);
    tests_run++;
    if (scr[0] !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_release: sc_reset %b expected 0", scr[0]);
    end
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (sh[0] || bsy[0]) act++;
    end
    word_valid = 1'b0;
    wq.delete();
    tests_run++;
    if (act !== 0) begin
      tests_failed++; $display("FAIL midreset_resume: %0d active cycles expected 0", act);
    end
  endtask

  task automatic test_start_abort();
    do_reset();
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    tests_run++;
    if (bsy[0] !== 1'b0 || scr[0] !== 1'b0) begin
      tests_failed++; $display("FAIL start_abort_idle: busy %b sc_reset %b expected 0 0", bsy[0], scr[0]);
    end
    // Holding start through CLEAR must not extend it.
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (scr[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      tests_failed++; $display("FAIL start_busy_ignored: sc_reset %b busy %b expected 0 1", scr[0], bsy[0]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_crc();
    logic [31:0] bits; int nbits, ndone, starve, bad_head, nclr;
    do_reset();
    wq = '{8'h00};
    run_load(2, 0, 0, 1'b0, bits, nbits, ndone, starve, bad_head, nclr);
    @(negedge clk);
    tests_run++;
    if (nbits !== 8 || ndone !== 1) begin
      tests_failed++; $display("FAIL crc_load: bits %0d done %0d expected 8 1", nbits, ndone);
    end
    tests_run++;
    if (crc_o[2] !== CRC_EXP) begin
      tests_failed++; $display("FAIL crc_value: got %h expected %h", crc_o[2], CRC_EXP);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (crc_o[2] !== CRC_EXP) begin
      tests_failed++; $display("FAIL crc_hold: got %h expected %h", crc_o[2], CRC_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_starvation();
    test_abort();
    test_reset_mid_load();
    test_start_abort();
    test_crc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
